multi_counter: RTL and testbench
================================

// Module: multi_counter
// PURPOSE
//   NUM_CH independent loadable up/down counters sharing one clock-prescaler tick.
//   Each channel runs in free-run, auto-reload or one-shot mode. Terminal events
//   set sticky, maskable interrupt flags, which are combined into one irq line.
//   Next-generation replacement for the single-channel 8-bit counter; sits on the peripheral timer bus.
// PARAMETERS
//   WIDTH    8  count width per channel
//   NUM_CH   4  number of channels
//   PRESC_W  8  prescaler width
// PORTS
//   clk         in   1               system clock, all logic on rising edge
//   rst_n       in   1               asynchronous active-low reset
//   prescale    in   PRESC_W         tick every prescale+1 clk cycles (0 = every cycle)
//   enable      in   NUM_CH          per-channel count enable
//   load        in   NUM_CH          per-channel synchronous load strobe
//   load_value  in   NUM_CH*WIDTH    load/reload value, channel i at [i*WIDTH +: WIDTH]
//   dir         in   NUM_CH          1 = count up, 0 = count down
//   mode        in   NUM_CH*2        per channel: 00 free-run, 01 auto-reload, 10 one-shot, 11 = free-run
//   irq_mask    in   NUM_CH          1 = pending flag drives irq
//   irq_clr     in   NUM_CH          write-1-to-clear pending flags
//   count       out  NUM_CH*WIDTH    current count, same packing as load_value
//   pending     out  NUM_CH          sticky terminal-event flags
//   done        out  NUM_CH          one-shot channel expired and stopped
//   irq         out  1               |(pending & irq_mask), registered
// BEHAVIOUR
//   - Reset (async, rst_n=0): count, reload regs, pending, done, irq, prescaler = 0. Effective immediately.
//   - Prescaler: a free-running counter that always runs. tick=1 in a cycle where presc_cnt==prescale.
//     In that cycle presc_cnt returns to 0, otherwise it increments.
//     A prescale change is honoured at the next compare; presc_cnt>prescale -> reset to 0 next cycle.
//   - Channel FSM: RUN / EXPIRED. EXPIRED is reachable only in one-shot mode. done = (state==EXPIRED).
//   - Priority per channel each cycle: load > advance > hold.
//   - load=1: count <= load_value, reload reg <= load_value, state <= RUN.
//     load does not need tick. No terminal event is generated.
//   - Advance = tick & enable & state==RUN & !load.
//   - Terminal value: 2^WIDTH-1 when dir=1, 0 when dir=0.
//   - Advance with count != terminal: count +/- 1 (mod 2^WIDTH).
//   - Advance with count == terminal (terminal event):
//       free-run:    count wraps (FF->00 up, 00->FF down).
//       auto-reload: count <= reload reg.
//       one-shot:    count holds at terminal, state <= EXPIRED.
//     pending[i] is set on the same edge.
//   - EXPIRED: advances are ignored and no further events occur. Only load or reset leaves this state.
//   - Changing mode or dir mid-run takes effect on the next advance. Terminal uses the current dir.
//   - pending: set-dominant. Terminal event and irq_clr in the same cycle -> flag stays 1.
//     irq_clr alone -> 0 next edge.
//   - irq is registered: it reflects pending & irq_mask one cycle after either changes.
//   - Latency: count is visible 1 cycle after the advancing edge. irq follows 1 cycle after pending.
//   - Channels are fully independent. Only the tick is shared.
// TESTING (WIDTH=8, NUM_CH=4)
//   1 ch0: up, free-run, prescale=0, load 0xFA, enable 6 cycles
//     -> count FB,FC,FD,FE,FF,00; pending[0]=1 at FF->00; irq=1 next cycle with mask[0]=1.
//   2 ch1: down, auto-reload, load 0x03, enable
//     -> 02,01,00,03,02; pending[1] set at 00->03; reload persists across repeated wraps.
//   3 ch2: up, one-shot, load 0xFE, enable
//     -> FF, then hold FF, done[2]=1, pending set once; irq_clr clears it and it stays 0.
//     load 0x10 -> done=0, counting resumes 11,12.
//   4 prescale=3, ch3 up, enable
//     -> count advances exactly every 4th clk. prescale 3->0 mid-run -> every clk after next tick.
//   5 Simultaneous events:
//     load with count==terminal and tick -> load_value taken, no pending.
//     irq_clr on terminal-event edge -> pending remains 1.
//   6 rst_n low mid-count (async, between edges)
//     -> all outputs 0 before the next clk edge. After release, counting starts only after a new load/enable.

Source files
------------

// File: rtl/multi_counter.sv
// NUM_CH loadable up/down counters sharing one prescaler tick, with free-run,
// auto-reload and one-shot modes and sticky maskable terminal-event flags.
module multi_counter #(
  parameter int WIDTH   = 8,
  parameter int NUM_CH  = 4,
  parameter int PRESC_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [NUM_CH-1:0]         load,
  input  logic [NUM_CH*WIDTH-1:0]   load_value,
  input  logic [NUM_CH-1:0]         dir,
  input  logic [NUM_CH*2-1:0]       mode,
  input  logic [NUM_CH-1:0]         irq_mask,
  input  logic [NUM_CH-1:0]         irq_clr,
  output logic [NUM_CH*WIDTH-1:0]   count,
  output logic [NUM_CH-1:0]         pending,
  output logic [NUM_CH-1:0]         done,
  output logic                      irq
);

  typedef enum logic {RUN = 1'b0, EXPIRED = 1'b1} state_t;

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               tick;
  logic [WIDTH-1:0]   count_q  [NUM_CH];
  logic [WIDTH-1:0]   count_d  [NUM_CH];
  logic [WIDTH-1:0]   reload_q [NUM_CH];
  logic [WIDTH-1:0]   reload_d [NUM_CH];
  state_t             state_q  [NUM_CH];
  state_t             state_d  [NUM_CH];
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic               irq_q, irq_d;

  function automatic logic at_terminal(input logic [WIDTH-1:0] c, input logic up);
    return up ? (c == {WIDTH{1'b1}}) : (c == {WIDTH{1'b0}});
  endfunction

  // A shrunk prescale below the running count restarts the period instead of wrapping.
  always_comb begin
    tick = (presc_cnt_q == prescale);
    if (tick || (presc_cnt_q > prescale)) presc_cnt_d = '0;
    else                                  presc_cnt_d = presc_cnt_q + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      count_d[i]   = count_q[i];
      reload_d[i]  = reload_q[i];
      state_d[i]   = state_q[i];
      pending_d[i] = pending_q[i] & ~irq_clr[i];
      if (load[i]) begin
        count_d[i]  = load_value[i*WIDTH +: WIDTH];
        reload_d[i] = load_value[i*WIDTH +: WIDTH];
        state_d[i]  = RUN;
      end else if (tick && enable[i] && (state_q[i] == RUN)) begin
        if (!at_terminal(count_q[i], dir[i])) begin
          count_d[i] = dir[i] ? count_q[i] + 1'b1 : count_q[i] - 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          case (mode[i*2 +: 2])
            2'b01:   count_d[i] = reload_q[i];
            2'b10:   state_d[i] = EXPIRED;
            default: count_d[i] = dir[i] ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
          endcase
        end
      end
    end
    irq_d = |(pending_q & irq_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_q <= '0;
      pending_q   <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        state_q[i]  <= RUN;
      end
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pending_q   <= pending_d;
      irq_q       <= irq_d;
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      count[i*WIDTH +: WIDTH] = count_q[i];
      done[i]                 = (state_q[i] == EXPIRED);
    end
  end

  assign pending = pending_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_multi_counter.sv
// Directed bench for multi_counter: modes, prescaler, simultaneous events, async reset.
module tb_multi_counter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  prescale;
  logic [3:0]  enable, load, dir, irq_mask, irq_clr;
  logic [31:0] load_value;
  logic [7:0]  mode;
  logic [31:0] count;
  logic [3:0]  pending, done;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  multi_counter #(.WIDTH(8), .NUM_CH(4), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .prescale(prescale), .enable(enable), .load(load),
    .load_value(load_value), .dir(dir), .mode(mode), .irq_mask(irq_mask),
    .irq_clr(irq_clr), .count(count), .pending(pending), .done(done), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ch(input int i);
    return count[i*8 +: 8];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; prescale = 8'd0; enable = '0; load = '0; load_value = '0;
    dir = '0; mode = '0; irq_mask = '0; irq_clr = '0;
    #12;
    n_checks++;
    if ({count, pending, done, irq} !== 41'd0) $display("FAIL reset_outputs got=%h want=0", {count, pending, done, irq});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    step();
    n_checks++;
    if (count !== 32'd0) $display("FAIL reset_hold count=%h want=0", count);
    else n_pass++;
  endtask

  task automatic test_free_run_up();
    logic [7:0] exp_cnt [6] = '{8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00};
    dir[0] = 1'b1; mode[1:0] = 2'b00; irq_mask = 4'b0001;
    load[0] = 1'b1; load_value[7:0] = 8'hFA;
    step();
    load[0] = 1'b0; enable[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (ch(0) !== exp_cnt[k]) $display("FAIL fr_count[%0d] got=%h want=%h", k, ch(0), exp_cnt[k]);
      else n_pass++;
      n_checks++;
      if (pending[0] !== (k == 5)) $display("FAIL fr_pending[%0d] got=%b want=%b", k, pending[0], (k == 5));
      else n_pass++;
    end
    n_checks++;
    if (irq !== 1'b0) $display("FAIL fr_irq_same_edge got=%b want=0", irq);
    else n_pass++;
    enable[0] = 1'b0;
    step();
    n_checks++;
    if (irq !== 1'b1) $display("FAIL fr_irq_next got=%b want=1", irq);
    else n_pass++;
    irq_clr[0] = 1'b1;
    step();
    irq_clr[0] = 1'b0;
    n_checks++;
    if (pending[0] !== 1'b0) $display("FAIL fr_clear got=%b want=0", pending[0]);
    else n_pass++;
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_cnt [8] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    logic       exp_pnd [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    dir[1] = 1'b0; mode[3:2] = 2'b01;
    load[1] = 1'b1; load_value[15:8] = 8'h03;
    step();
    load[1] = 1'b0; enable[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (ch(1) !== exp_cnt[k] || pending[1] !== exp_pnd[k])
        $display("FAIL ar_step[%0d] count=%h pending=%b want count=%h pending=%b", k, ch(1), pending[1], exp_cnt[k], exp_pnd[k]);
      else n_pass++;
    end
    enable[1] = 1'b0;
  endtask

  task automatic test_one_shot();
    dir[2] = 1'b1; mode[5:4] = 2'b10;
    load[2] = 1'b1; load_value[23:16] = 8'hFE;
    step();
    load[2] = 1'b0; enable[2] = 1'b1;
    step();
    n_checks++;
    if (ch(2) !== 8'hFF || done[2] !== 1'b0 || pending[2] !== 1'b0)
      $display("FAIL os_ff count=%h done=%b pending=%b want FF/0/0", ch(2), done[2], pending[2]);
    else n_pass++;
    step();
    n_checks++;
    if (ch(2) !== 8'hFF || done[2] !== 1'b1 || pending[2] !== 1'b1)
      $display("FAIL os_expire count=%h done=%b pending=%b want FF/1/1", ch(2), done[2], pending[2]);
    else n_pass++;
    irq_clr[2] = 1'b1;
    step();
    irq_clr[2] = 1'b0;
    step(); step();
    n_checks++;
    if (ch(2) !== 8'hFF || done[2] !== 1'b1 || pending[2] !== 1'b0)
      $display("FAIL os_hold count=%h done=%b pending=%b want FF/1/0", ch(2), done[2], pending[2]);
    else n_pass++;
    load[2] = 1'b1; load_value[23:16] = 8'h10;
    step();
    load[2] = 1'b0;
    n_checks++;
    if (ch(2) !== 8'h10 || done[2] !== 1'b0) $display("FAIL os_reload count=%h done=%b want 10/0", ch(2), done[2]);
    else n_pass++;
    step(); step();
    n_checks++;
    if (ch(2) !== 8'h12) $display("FAIL os_resume count=%h want 12", ch(2));
    else n_pass++;
    enable[2] = 1'b0;
  endtask

  task automatic test_prescaler();
    logic [7:0] exp_cnt [13] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2,
                                 8'd2, 8'd3, 8'd4, 8'd5};
    dir[3] = 1'b1; mode[7:6] = 2'b00; prescale = 8'd3;
    load[3] = 1'b1; load_value[31:24] = 8'h00; enable[3] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      load[3] = 1'b0;
      if (k == 8) prescale = 8'd0;
      n_checks++;
      if (ch(3) !== exp_cnt[k]) $display("FAIL presc_edge[%0d] count=%0d want=%0d", k + 1, ch(3), exp_cnt[k]);
      else n_pass++;
    end
    enable[3] = 1'b0;
  endtask

  task automatic test_simultaneous();
    dir[0] = 1'b1; mode[1:0] = 2'b00; enable[0] = 1'b1;
    load[0] = 1'b1; load_value[7:0] = 8'hFF;
    step();
    load_value[7:0] = 8'h55;
    step();
    n_checks++;
    if (ch(0) !== 8'h55 || pending[0] !== 1'b0)
      $display("FAIL load_over_terminal count=%h pending=%b want 55/0", ch(0), pending[0]);
    else n_pass++;
    load_value[7:0] = 8'hFF;
    step();
    load[0] = 1'b0; irq_clr[0] = 1'b1;
    step();
    n_checks++;
    if (ch(0) !== 8'h00 || pending[0] !== 1'b1)
      $display("FAIL set_dominant count=%h pending=%b want 00/1", ch(0), pending[0]);
    else n_pass++;
    step();
    n_checks++;
    if (pending[0] !== 1'b0) $display("FAIL clr_alone pending=%b want 0", pending[0]);
    else n_pass++;
    irq_clr[0] = 1'b0; enable[0] = 1'b0;
  endtask

  task automatic test_async_reset();
    irq_mask = 4'hF;
    step();
    n_checks++;
    if (irq !== 1'b1 || ch(3) !== 8'd5) $display("FAIL pre_reset irq=%b ch3=%h want 1/05", irq, ch(3));
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({count, pending, done, irq} !== 41'd0) $display("FAIL async_reset got=%h want=0", {count, pending, done, irq});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    n_checks++;
    if (count !== 32'd0 || pending !== 4'd0) $display("FAIL post_reset_idle count=%h pending=%h want 0/0", count, pending);
    else n_pass++;
    enable[0] = 1'b1;
    step();
    n_checks++;
    if (ch(0) !== 8'h01) $display("FAIL post_reset_count got=%h want 01", ch(0));
    else n_pass++;
    enable[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run_up();
    test_auto_reload();
    test_one_shot();
    test_prescaler();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
